alu_core: RTL
=============

ALU_CORE -- requirements
Module: alu_core

Interface
REQ-001 SHALL have parameter: ALU_OUT_RESULT_WIDTH, default 16, result width; operand width W = ALU_OUT_RESULT_WIDTH/2 (must be even, >=4).
REQ-002 SHALL have port: clk  input  1  the only clock, all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port: valid  input  1  request qualifier from ALU_in agent.
REQ-005 SHALL have port: op  input  3  opcode: 0 no_op, 1 add, 2 and, 3 xor, 4 mul, 7 rst_op, 5/6 reserved.
REQ-006 SHALL have port: a  input  W  operand A.
REQ-007 SHALL have port: b  input  W  operand B.
REQ-008 SHALL have port: ready  output  1  high when a request can be accepted.
REQ-009 SHALL have port: done  output  1  one-cycle completion pulse to ALU_out agent.
REQ-010 SHALL have port: result  output  ALU_OUT_RESULT_WIDTH  operation result, driven to ALU_out agent.

Function
REQ-011 SHALL implement FSM states IDLE, EXEC, MUL; ready = 1 only in IDLE.
REQ-012 SHALL accept a request on a rising edge where valid=1 and ready=1 (edge N), registering op, a and b.
REQ-013 SHALL treat no_op and reserved opcodes 5/6 as accepted, stay in IDLE, leave result unchanged, never pulse done.
REQ-014 SHALL, on rst_op accept, clear result to 0 at edge N, stay in IDLE, never pulse done.
REQ-015 SHALL, for add/and/xor, go IDLE->EXEC at edge N, then at edge N+1 load result and set done=1, return to IDLE.
REQ-016 SHALL compute add as zero-extended a+b (carry lands in bit W, no truncation), and/xor as zero-extended bitwise result.
REQ-017 SHALL, for mul, go IDLE->MUL at edge N, run one shift-add step per cycle with a counter, load full 2W-bit product and set done=1 at edge N+W, return to IDLE.
REQ-018 SHALL hold done high for exactly one cycle per completed add/and/xor/mul; ready rises in the same cycle done is high.
REQ-019 SHALL ignore valid and operand changes while not in IDLE (no queuing, no corruption of the in-flight operation).
REQ-020 SHALL hold result stable between completions; result changes only at a done edge or rst_op accept.
REQ-021 SHALL support back-to-back requests: a request presented with valid=1 while done=1 is accepted at that edge.

Reset
REQ-022 SHALL, when rst=0 at a rising edge, force state IDLE, done=0, result=0, mul counter=0, ready=1 from the following cycle.
REQ-023 SHALL abort any in-flight operation on reset mid-operation; no done pulse for it after reset release.
REQ-024 SHALL not accept requests on any edge where rst=0.

Configuration
REQ-025 SHALL, with macro ALU_CORE_MUL_EN defined, implement mul per REQ-017.
REQ-026 SHALL, without ALU_CORE_MUL_EN, omit the MUL state and multiplier datapath and treat opcode 4 as no_op per REQ-013.

Verification
REQ-027 SHALL cover: W=8, add a=8'hFF b=8'h01 -> done one cycle at edge N+1, result=16'h0100.
REQ-028 SHALL cover: xor a=8'hA5 b=8'h0F accepted in the done cycle of a prior and -> both complete, results 16'h0005 and 16'h00AA in consecutive done pulses two cycles apart.
REQ-029 SHALL cover (MUL_EN): mul a=8'hFF b=8'hFF -> ready=0 for 8 cycles, done at edge N+8, result=16'hFE01; valid toggled mid-op is ignored.
REQ-030 SHALL cover: add result 16'h0003, then rst_op -> result=0, no done; then no_op -> no done, result stays 0.
REQ-031 SHALL cover: rst=0 asserted at edge N+3 of a mul -> done never pulses, result=0, ready=1 after release, new add a=1 b=2 -> result=16'h0003.
REQ-032 SHALL cover (MUL_EN undefined): op=4 a=3 b=5 -> no done, ready stays 1, result unchanged.

Source files
------------

// File: rtl/alu_core.sv
`default_nettype none
// =============================================================================
// Module   : alu_core
// Brief    : Multi-cycle ALU (add/and/xor, optional shift-add mul) with a
//            valid/ready request side and a one-cycle done pulse.
// Options  : ALU_CORE_MUL_EN - include the MUL state and shift-add multiplier
// Revision : 1.0 - initial release
// =============================================================================
module alu_core #(
   parameter int ALU_OUT_RESULT_WIDTH = 16
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              valid,
   input  logic [2:0]                        op,
   input  logic [ALU_OUT_RESULT_WIDTH/2-1:0] a,
   input  logic [ALU_OUT_RESULT_WIDTH/2-1:0] b,
   output logic                              ready,
   output logic                              done,
   output logic [ALU_OUT_RESULT_WIDTH-1:0]   result
);

   localparam int c_w  = ALU_OUT_RESULT_WIDTH / 2;
   localparam int c_rw = ALU_OUT_RESULT_WIDTH;

   localparam logic [2:0] c_op_add = 3'd1;
   localparam logic [2:0] c_op_and = 3'd2;
   localparam logic [2:0] c_op_xor = 3'd3;
   localparam logic [2:0] c_op_mul = 3'd4;
   localparam logic [2:0] c_op_rst = 3'd7;

`ifdef ALU_CORE_MUL_EN
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_MUL  = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1
   } state_t;
`endif

   state_t            r_state;
   state_t            w_state_next;
   logic [2:0]        r_op;
   logic [c_w-1:0]    r_a;
   logic [c_w-1:0]    r_b;
   logic [c_rw-1:0]   r_result;
   logic              r_done;

   logic              w_accept;
   logic              w_clear;
   logic              w_exec_done;
   logic              w_mul_done;
   logic [c_w:0]      w_sum;
   logic [c_rw-1:0]   w_exec_res;

`ifdef ALU_CORE_MUL_EN
   localparam int c_cw = $clog2(c_w);

   logic [c_cw-1:0]   r_cnt;
   logic [c_rw-1:0]   r_mcand;
   logic [c_rw-1:0]   r_acc;
   logic [c_rw-1:0]   w_acc_next;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_clear      = 1'b0;
      w_exec_done  = 1'b0;
      w_mul_done   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (valid) begin
               w_accept = 1'b1;
               case (op)
                  c_op_add, c_op_and, c_op_xor: w_state_next = ST_EXEC;
`ifdef ALU_CORE_MUL_EN
                  c_op_mul:                     w_state_next = ST_MUL;
`endif
                  c_op_rst:                     w_clear      = 1'b1;
                  default:                      w_state_next = ST_IDLE;
               endcase
            end
         end
         ST_EXEC: begin
            w_exec_done  = 1'b1;
            w_state_next = ST_IDLE;
         end
`ifdef ALU_CORE_MUL_EN
         ST_MUL: begin
            if (r_cnt == c_cw'(c_w - 1)) begin
               w_mul_done   = 1'b1;
               w_state_next = ST_IDLE;
            end
         end
`endif
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Single-cycle results are zero-extended into the full result width
   always_comb begin
      w_sum = {1'b0, r_a} + {1'b0, r_b};
      case (r_op)
         c_op_add: w_exec_res = {{(c_w-1){1'b0}}, w_sum};
         c_op_and: w_exec_res = {{c_w{1'b0}}, r_a & r_b};
         c_op_xor: w_exec_res = {{c_w{1'b0}}, r_a ^ r_b};
         default:  w_exec_res = '0;
      endcase
   end

`ifdef ALU_CORE_MUL_EN
   // One partial product per cycle: multiplier LSB gates the shifted multiplicand
   always_comb begin
      w_acc_next = r_acc + (r_b[0] ? r_mcand : '0);
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_op     <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_result <= '0;
         r_done   <= 1'b0;
`ifdef ALU_CORE_MUL_EN
         r_cnt    <= '0;
         r_mcand  <= '0;
         r_acc    <= '0;
`endif
      end else begin
         r_done <= w_exec_done | w_mul_done;
         if (w_accept) begin
            r_op <= op;
            r_a  <= a;
            r_b  <= b;
`ifdef ALU_CORE_MUL_EN
            r_mcand <= {{c_w{1'b0}}, a};
            r_acc   <= '0;
            r_cnt   <= '0;
`endif
         end
         if (w_clear) begin
            r_result <= '0;
         end else if (w_exec_done) begin
            r_result <= w_exec_res;
         end
`ifdef ALU_CORE_MUL_EN
         else if (w_mul_done) begin
            r_result <= w_acc_next;
         end
         if (r_state == ST_MUL) begin
            r_acc   <= w_acc_next;
            r_mcand <= r_mcand << 1;
            r_b     <= r_b >> 1;
            r_cnt   <= r_cnt + 1'b1;
         end
`endif
      end
   end

   assign ready  = (r_state == ST_IDLE);
   assign done   = r_done;
   assign result = r_result;

endmodule
`default_nettype wire
